// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: shared CPU fetch definitions (FSM states and PC defaults).
package pc_unit_pkg;
   typedef enum logic {RUN = 1'b0, HALTED = 1'b1} pcState_t;
   localparam int DEFAULT_INC = 2;
   localparam int DEFAULT_RESET_VECTOR = 0;
endpackage

// File: rtl/pc_reg_n.sv
// pc_reg_n: WIDTH-bit PC register with write enable and async active-low reset.
module pc_reg_n #(
   parameter int WIDTH = 16,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   always_ff @(posedge clk or negedge rst)
      if (!rst) q <= RESET_VECTOR;
      else if (we) q <= d;
endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter with redirect/stall priority and a RUN/HALTED fetch FSM.
module pc_unit import pc_unit_pkg::*; #(
   parameter int WIDTH = 16,
   parameter int INC = DEFAULT_INC,
   parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             redirect,
   input  logic [WIDTH-1:0] target,
   input  logic             halt,
   input  logic             resume,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_plus,
   output logic             halted,
   output logic             redirected
);
   pcState_t state, nextState;
   logic pcWe;
   logic [WIDTH-1:0] nextPc;
   logic running;
   assign running = (state == RUN);
   assign pc_plus = pc + WIDTH'(INC);
   assign halted = (state == HALTED);
   // Priority in RUN: redirect, then stall, then halt; HALTED only listens to resume.
   always_comb begin
      pcWe = running & (redirect | ~(stall | halt));
      nextPc = redirect ? target : pc_plus;
      nextState = running ? ((!redirect && !stall && halt) ? HALTED : RUN)
                          : (resume ? RUN : HALTED);
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= RUN;
         redirected <= 1'b0;
      end else begin
         state <= nextState;
         redirected <= running & redirect;
      end
   pc_reg_n #(.WIDTH(WIDTH), .RESET_VECTOR(RESET_VECTOR)) pcReg (
      .clk(clk), .rst(rst), .we(pcWe), .d(nextPc), .q(pc)
   );
endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter WIDTH, default 16, PC and target width in bits (legal range 8..32).
REQ-002 Parameter INC, default 2, sequential increment added to PC each advancing cycle.
REQ-003 Parameter RESET_VECTOR, default 0, PC value loaded on reset, WIDTH bits.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-low.
REQ-006 stall  input  1  hold PC for this cycle.
REQ-007 redirect  input  1  branch/jump taken; load target this cycle.
REQ-008 target  input  WIDTH  redirect destination address.
REQ-009 halt  input  1  HLT decoded; stop fetch after this cycle.
REQ-010 resume  input  1  leave HALTED state at current PC.
REQ-011 pc  output  WIDTH  current PC, registered.
REQ-012 pc_plus  output  WIDTH  pc + INC, combinational, modulo 2^WIDTH.
REQ-013 halted  output  1  high while in HALTED state, registered.
REQ-014 redirected  output  1  one-cycle pulse, registered, high the cycle after a redirect is accepted.

Function
REQ-015 The two-state FSM SHALL have states RUN and HALTED; reset state is RUN.
REQ-016 In RUN, the next PC SHALL follow priority: redirect -> target; else stall -> hold; else halt -> hold; else pc + INC.
REQ-017 In RUN, halt=1 with redirect=0 and stall=0 SHALL move the FSM to HALTED at the next edge, with pc held.
REQ-018 In RUN, halt=1 with stall=1 SHALL be ignored; PC holds and FSM stays RUN.
REQ-019 In RUN, halt=1 with redirect=1 SHALL take the redirect and ignore halt.
REQ-020 In HALTED, pc SHALL hold and stall, halt and redirect SHALL be ignored.
REQ-021 In HALTED, resume=1 SHALL return the FSM to RUN at the next edge with pc unchanged; resume in RUN is ignored.
REQ-022 Latency: an accepted redirect SHALL appear on pc exactly one edge after being sampled.
REQ-023 PC arithmetic SHALL wrap modulo 2^WIDTH with no overflow flag (0xFFFE + 2 -> 0x0000 at WIDTH=16).
REQ-024 target SHALL be loaded unmodified; no alignment masking.
REQ-025 redirected SHALL be 1 for exactly one cycle per accepted redirect; back-to-back redirects give back-to-back pulses.

Reset
REQ-026 rst=0 SHALL asynchronously force pc=RESET_VECTOR, FSM=RUN, halted=0, redirected=0, regardless of clk.
REQ-027 Reset asserted mid-operation (including in HALTED or on a redirect edge) SHALL override all inputs.
REQ-028 After rst deasserts, the first rising edge SHALL perform normal next-PC selection.

Structure
REQ-029 FSM state encoding (RUN, HALTED) and the default INC and RESET_VECTOR SHALL live in the shared CPU package.
REQ-030 The PC storage SHALL be one sub-module, pc_reg_n: WIDTH-bit register with async active-low reset to RESET_VECTOR and a write enable; next-PC mux and FSM stay in pc_unit.
REQ-031 No latches; all outputs except pc_plus SHALL be flop-driven.

Verification
REQ-032 Reset then 4 free-running cycles, WIDTH=16 -> pc = 0x0000, 0x0002, 0x0004, 0x0006, 0x0008; halted=0.
REQ-033 At pc=0x0008, redirect=1, target=0x0123 for one cycle -> next pc=0x0123, redirected=1 for one cycle, then pc=0x0125.
REQ-034 At pc=0x0200, stall=1 for 3 cycles, halt=1 in the second -> pc holds 0x0200 throughout; FSM stays RUN.
REQ-035 At pc=0x0300, halt=1 -> halted=1, pc holds 0x0300 across 5 cycles with redirect=1, target=0xF0F0; resume=1 -> halted=0, then pc=0x0302.
REQ-036 Redirect target=0xFFFE, then free-run -> pc = 0xFFFE, 0x0000, 0x0002 (wrap).
REQ-037 From HALTED at 0x0400, assert rst=0 mid-cycle -> pc=0x0000 and halted=0 before the next edge; repeat with WIDTH=32, RESET_VECTOR=0x1000, INC=4 -> pc = 0x1000, 0x1004.
